// File: rtl/corner_pkg.sv
// Shared types, limits and default corners for the corner tracker.
// Frame geometry is 800x600; corner addresses are {row, col}.
package corner_pkg;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
    } corner_t;

    localparam logic [9:0] H_MAX = 10'd799;
    localparam logic [9:0] V_MAX = 10'd599;

    localparam corner_t DEF_UL = {10'd0,  10'd0};
    localparam corner_t DEF_UR = {10'd0,  H_MAX};
    localparam corner_t DEF_DL = {V_MAX,  10'd0};
    localparam corner_t DEF_DR = {V_MAX,  H_MAX};

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, COAST} track_state_t;

    typedef enum logic [2:0] {
        PH_IDLE, PH_CHECK, PH_UL, PH_UR, PH_DL, PH_DR, PH_DONE
    } phase_t;

    typedef enum logic [1:0] {LD_HOLD, LD_DIRECT, LD_SMOOTH, LD_DEFAULT} load_t;

    function automatic logic [10:0] manhattan(input corner_t a, input corner_t b);
        logic [9:0] drow;
        logic [9:0] dcol;
        drow = (a.row > b.row) ? (a.row - b.row) : (b.row - a.row);
        dcol = (a.col > b.col) ? (a.col - b.col) : (b.col - a.col);
        return {1'b0, drow} + {1'b0, dcol};
    endfunction

    // idx order matches the update sequence: UL, UR, DL, DR.
    function automatic corner_t default_corner(input logic [1:0] idx);
        corner_t c;
        case (idx)
            2'd0:    c = DEF_UL;
            2'd1:    c = DEF_UR;
            2'd2:    c = DEF_DL;
            default: c = DEF_DR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/corner_ema.sv
// One combinational smoothing step for a single coordinate: moves cur toward
// meas by diff >>> SHIFT (at least one unit when diff is nonzero), clamped to 0..MAX.
module corner_ema #(
    parameter int         SHIFT = 2,
    parameter logic [9:0] MAX   = 10'd799
) (
    input  logic [9:0] cur,
    input  logic [9:0] meas,
    output logic [9:0] result
);

    logic signed [10:0] diff;
    logic signed [10:0] step;
    logic signed [11:0] sum;

    always_comb begin
        diff = $signed({1'b0, meas}) - $signed({1'b0, cur});
        step = diff >>> SHIFT;
        // A positive diff smaller than 2^SHIFT would otherwise stall short of the target.
        if ((step == 11'sd0) && (diff != 11'sd0)) begin
            step = diff[10] ? -11'sd1 : 11'sd1;
        end
        sum = $signed({step[10], step}) + $signed({2'b00, cur});
        if (sum[11]) begin
            result = 10'd0;
        end else if (sum > $signed({2'b00, MAX})) begin
            result = MAX;
        end else begin
            result = sum[9:0];
        end
    end

endmodule

// File: rtl/corner_tracker.sv
// Tracks the four document corners across frames with a SEARCH/ACQUIRE/LOCKED/COAST
// state machine. Define CORNER_TRACKER_SMOOTH_EN to smooth corners while locked.
module corner_tracker
    import corner_pkg::*;
#(
    parameter int SHIFT       = 2,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOSS_FRAMES = 4,
    parameter int JUMP_THR    = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_success,
    input  logic [19:0]  i_ul_addr,
    input  logic [19:0]  i_ur_addr,
    input  logic [19:0]  i_dl_addr,
    input  logic [19:0]  i_dr_addr,
    output logic [19:0]  o_ul_addr,
    output logic [19:0]  o_ur_addr,
    output logic [19:0]  o_dl_addr,
    output logic [19:0]  o_dr_addr,
    output logic         o_valid,
    output logic         o_locked,
    output logic         o_busy,
    output track_state_t o_state
);

    // Handshake: i_valid is a one-cycle pulse accepted only while o_busy is low;
    // there is no backpressure, a pulse seen while busy is dropped. o_valid pulses
    // once per accepted frame, six cycles after acceptance.

    localparam logic [7:0]  ACQ_N  = 8'(ACQ_FRAMES);
    localparam logic [7:0]  LOSS_N = 8'(LOSS_FRAMES);
    localparam logic [10:0] THR    = 11'(JUMP_THR);

`ifdef CORNER_TRACKER_SMOOTH_EN
    localparam load_t TRACK_LOAD = LD_SMOOTH;
`else
    localparam load_t TRACK_LOAD = LD_DIRECT;
`endif

    if ((SHIFT < 0) || (SHIFT > 10) || (ACQ_FRAMES < 1) || (LOSS_FRAMES < 1)) begin : g_bad_cfg
        $error("corner_tracker: unsupported parameter set");
    end

    phase_t       phase_q, phase_d;
    track_state_t state_q, state_d;
    logic [7:0]   acq_q, acq_d;
    logic [7:0]   miss_q, miss_d;
    load_t        mode_q, mode_d;
    corner_t      cap_q [4];
    logic         cap_ok_q;
    corner_t      trk_q [4];
    logic         valid_q;

    logic         accept;
    logic         near;
    logic         good;
    logic         upd;
    logic [1:0]   idx;
    corner_t      cur;
    corner_t      meas;
    corner_t      next_c;

    assign accept = i_valid && (phase_q == PH_IDLE);

    // Frame sequencing FSM.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:  if (i_valid) phase_d = PH_CHECK;
            PH_CHECK: phase_d = PH_UL;
            PH_UL:    phase_d = PH_UR;
            PH_UR:    phase_d = PH_DL;
            PH_DL:    phase_d = PH_DR;
            PH_DR:    phase_d = PH_DONE;
            PH_DONE:  phase_d = PH_IDLE;
            default:  phase_d = PH_IDLE;
        endcase
    end

    always_comb begin
        near = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (manhattan(cap_q[i], trk_q[i]) > THR) near = 1'b0;
        end
        good = cap_ok_q && ((state_q == SEARCH) || (state_q == ACQUIRE) || near);
    end

    // Track FSM: evaluated once per frame in the CHECK cycle; mode_d tells the
    // update cycles how to load the four corners.
    always_comb begin
        state_d = state_q;
        acq_d   = acq_q;
        miss_d  = miss_q;
        mode_d  = mode_q;
        if (phase_q == PH_CHECK) begin
            mode_d = LD_HOLD;
            case (state_q)
                SEARCH: begin
                    if (good) begin
                        state_d = ACQUIRE;
                        acq_d   = 8'd1;
                        mode_d  = LD_DIRECT;
                    end
                end
                ACQUIRE: begin
                    if (good) begin
                        acq_d  = acq_q + 8'd1;
                        mode_d = LD_DIRECT;
                        if ((acq_q + 8'd1) >= ACQ_N) begin
                            state_d = LOCKED;
                            acq_d   = 8'd0;
                        end
                    end else begin
                        state_d = SEARCH;
                        acq_d   = 8'd0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        mode_d = TRACK_LOAD;
                    end else begin
                        state_d = COAST;
                        miss_d  = 8'd1;
                    end
                end
                default: begin
                    if (good) begin
                        state_d = LOCKED;
                        miss_d  = 8'd0;
                        mode_d  = TRACK_LOAD;
                    end else begin
                        miss_d = miss_q + 8'd1;
                        if ((miss_q + 8'd1) >= LOSS_N) begin
                            state_d = SEARCH;
                            miss_d  = 8'd0;
                            mode_d  = LD_DEFAULT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= PH_IDLE;
            state_q <= SEARCH;
            acq_q   <= 8'd0;
            miss_q  <= 8'd0;
            mode_q  <= LD_HOLD;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            state_q <= state_d;
            acq_q   <= acq_d;
            miss_q  <= miss_d;
            mode_q  <= mode_d;
            valid_q <= (phase_q == PH_DONE);
        end
    end

    // One corner per update cycle; both coordinate steppers are shared across corners.
    always_comb begin
        case (phase_q)
            PH_UR:   idx = 2'd1;
            PH_DL:   idx = 2'd2;
            PH_DR:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        upd  = (phase_q == PH_UL) || (phase_q == PH_UR) ||
               (phase_q == PH_DL) || (phase_q == PH_DR);
        cur  = trk_q[idx];
        meas = cap_q[idx];
    end

`ifdef CORNER_TRACKER_SMOOTH_EN
    logic [9:0] smooth_row;
    logic [9:0] smooth_col;

    corner_ema #(.SHIFT(SHIFT), .MAX(V_MAX)) u_ema_row (
        .cur    (cur.row),
        .meas   (meas.row),
        .result (smooth_row)
    );

    corner_ema #(.SHIFT(SHIFT), .MAX(H_MAX)) u_ema_col (
        .cur    (cur.col),
        .meas   (meas.col),
        .result (smooth_col)
    );
`endif

    always_comb begin
        case (mode_q)
            LD_DIRECT:  next_c = meas;
`ifdef CORNER_TRACKER_SMOOTH_EN
            LD_SMOOTH:  next_c = {smooth_row, smooth_col};
`endif
            LD_DEFAULT: next_c = default_corner(idx);
            default:    next_c = cur;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cap_ok_q <= 1'b0;
            for (int i = 0; i < 4; i++) cap_q[i] <= '0;
            trk_q[0] <= DEF_UL;
            trk_q[1] <= DEF_UR;
            trk_q[2] <= DEF_DL;
            trk_q[3] <= DEF_DR;
        end else begin
            if (accept) begin
                cap_ok_q <= i_success;
                cap_q[0] <= i_ul_addr;
                cap_q[1] <= i_ur_addr;
                cap_q[2] <= i_dl_addr;
                cap_q[3] <= i_dr_addr;
            end
            if (upd) trk_q[idx] <= next_c;
        end
    end

    assign o_ul_addr = trk_q[0];
    assign o_ur_addr = trk_q[1];
    assign o_dl_addr = trk_q[2];
    assign o_dr_addr = trk_q[3];
    assign o_valid   = valid_q;
    assign o_busy    = (phase_q != PH_IDLE);
    assign o_locked  = (state_q == LOCKED) || (state_q == COAST);
    assign o_state   = state_q;

endmodule

// File: doc/corner_tracker.md
CORNER_TRACKER -- requirements
Module: corner_tracker

Interface
REQ-001 Parameter SHIFT, default 2: smoothing shift; each update moves a coordinate by 1/2^SHIFT of the error.
REQ-002 Parameter ACQ_FRAMES, default 3: consecutive good frames that SHALL move ACQUIRE to LOCKED.
REQ-003 Parameter LOSS_FRAMES, default 4: consecutive bad frames that SHALL move COAST to SEARCH.
REQ-004 Parameter JUMP_THR, default 64: maximum per-corner Manhattan jump accepted while locked.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst  in  1  asynchronous, active-high reset.
REQ-007 i_valid  in  1  one-cycle frame-done pulse from the corner finder.
REQ-008 i_success  in  1  corner finder found a quadrilateral this frame.
REQ-009 i_ul_addr, i_ur_addr, i_dl_addr, i_dr_addr  in  20 each  measured corners, {row[19:10], col[9:0]}.
REQ-010 o_ul_addr, o_ur_addr, o_dl_addr, o_dr_addr  out  20 each  tracked corners, same format.
REQ-011 o_valid  out  1  one-cycle pulse when tracked corners are updated.
REQ-012 o_locked  out  1  high in LOCKED or COAST.
REQ-013 o_busy  out  1  high while a frame is being processed.

Function
REQ-014 Timing: i_valid sampled at edge N SHALL capture all inputs; N+1 CHECK; N+2..N+5 UPDATE corners UL, UR, DL, DR; o_valid high for exactly cycle N+6, with outputs final in that cycle.
REQ-015 i_valid arriving while o_busy is high SHALL be ignored; i_success and addresses SHALL be ignored whenever i_valid is low.
REQ-016 CHECK: distance = |drow| + |dcol| (11-bit unsigned) between each captured corner and the current output; good = captured success AND (state is SEARCH/ACQUIRE OR all four distances <= JUMP_THR).
REQ-017 SEARCH: good -> ACQUIRE with acq_cnt=1; bad -> stay.
REQ-018 ACQUIRE: good -> acq_cnt+1, and LOCKED once acq_cnt equals ACQ_FRAMES; bad -> SEARCH.
REQ-019 LOCKED: good -> stay; bad -> COAST with miss_cnt=1.
REQ-020 COAST: good -> LOCKED with miss_cnt=0; bad -> miss_cnt+1, and SEARCH once miss_cnt equals LOSS_FRAMES.
REQ-021 Output load: in SEARCH/ACQUIRE on good frames outputs SHALL equal the captured corners directly; in LOCKED/COAST on good frames outputs SHALL be smoothed; on bad frames outputs SHALL hold.
REQ-022 On the COAST->SEARCH transition, outputs SHALL revert to defaults UL {0,0}, UR {0,799}, DL {599,0}, DR {599,799}.
REQ-023 Smoothing step per coordinate: diff = meas - cur (11-bit signed); step = diff >>> SHIFT (arithmetic); if step is 0 and diff is nonzero, step = sign(diff) (+1/-1); result clamped to rows 0..599 and cols 0..799.
REQ-024 o_valid SHALL pulse for every accepted frame, good or bad.

Reset
REQ-025 While i_rst is high: state SEARCH, counters 0, o_valid 0, o_busy 0, o_locked 0, outputs at REQ-022 defaults.
REQ-026 Reset asserted mid-processing SHALL abort the frame with no o_valid pulse; the first i_valid after release SHALL be processed normally.

Configuration
REQ-027 Macro CORNER_TRACKER_SMOOTH_EN defined: REQ-023 smoothing applies in LOCKED/COAST.
REQ-028 Macro absent: LOCKED/COAST good frames SHALL load captured corners directly; the smoothing logic SHALL not be built; timing per REQ-014 unchanged.

Structure
REQ-029 Package corner_pkg SHALL hold: corner address struct {row, col} of 10 bits each, H_MAX=799, V_MAX=599, four default-corner constants, track-state enum {SEARCH, ACQUIRE, LOCKED, COAST}.
REQ-030 Sub-module corner_ema: one combinational coordinate step (REQ-023 with clamp), instantiated twice (row, col) and time-shared over the four UPDATE cycles.

Verification
REQ-031 After reset, three good frames with UL {100,100}: o_valid 6 cycles after each i_valid; o_locked rises with frame 3; o_ul_addr = {100,100}.
REQ-032 Locked at UL {100,100}, SHIFT=2, measurement {108,100}: successive outputs rows 102, 103, 104, ... reaching 108 (unit step when diff < 4).
REQ-033 Locked, UR jump of 65 px with success=1: frame treated as bad -> COAST, outputs held, o_locked stays 1.
REQ-034 Locked, four success=0 frames: COAST after frame 1, SEARCH after frame 4 with default corners and o_locked=0; one good frame in between instead returns to LOCKED.
REQ-035 Second i_valid at N+3: ignored, single o_valid at N+6; i_rst pulse at N+4: no o_valid, reset values.
REQ-036 Macro undefined, locked, measurement {108,100}: o_ul_addr = {108,100} on the next o_valid.
